// File: rtl/btb_assoc.sv
// btb_assoc: N-way set-associative branch target buffer.
// Lookups are answered one cycle later from registered outputs; resolved
// branches are written back through the update port. Each entry keeps a
// 2-bit saturating direction counter, each set a round-robin victim pointer.
// Optional build macro: BTB_STATS_EN adds stat_lookups / stat_hits counters.
module btb_assoc #(
    parameter int ADDR_W = 32,
    parameter int SETS   = 64,
    parameter int WAYS   = 2
) (
    input  logic              sysclk,
    input  logic              nrst,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_pc,
    output logic              lu_hit,
    output logic              lu_taken,
    output logic [ADDR_W-1:0] lu_target,
    input  logic              up_valid,
    input  logic [ADDR_W-1:0] up_pc,
    input  logic              up_taken,
    input  logic [ADDR_W-1:0] up_target,
    input  logic              flush
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_hits
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    // Entry storage kept in flops so reset and flush clear every valid bit at once.
    logic              valid_q  [SETS][WAYS];
    logic [1:0]        ctr_q    [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q    [SETS][WAYS];
    logic [ADDR_W-1:0] target_q [SETS][WAYS];
    logic [WAY_W-1:0]  rr_q     [SETS];

    logic [IDX_W-1:0]  lu_idx, up_idx;
    logic [TAG_W-1:0]  lu_tag, up_tag;

    assign lu_idx = lu_pc[IDX_W+1:2];
    assign lu_tag = lu_pc[ADDR_W-1:IDX_W+2];
    assign up_idx = up_pc[IDX_W+1:2];
    assign up_tag = up_pc[ADDR_W-1:IDX_W+2];

    logic             lu_match;
    logic [WAY_W-1:0] lu_way;

    // Lookup tag compare; scanning downward leaves the lowest matching way selected.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        lu_match = 1'b0;
        lu_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[lu_idx][w] && tag_q[lu_idx][w] == lu_tag) begin
                lu_match = 1'b1;
                lu_way   = WAY_W'(w);
            end
        end
    end

    logic             up_match;
    logic [WAY_W-1:0] up_hit_way;
    logic             have_free;
    logic [WAY_W-1:0] free_way;
    logic [WAY_W-1:0] wr_way;
    logic             evict;
    logic             do_update;

    // Update-side compare plus victim choice: hit way, else lowest invalid way, else rr.
    always_comb begin
        up_match   = 1'b0;
        up_hit_way = '0;
        have_free  = 1'b0;
        free_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
                up_match   = 1'b1;
                up_hit_way = WAY_W'(w);
            end
            if (!valid_q[up_idx][w]) begin
                have_free = 1'b1;
                free_way  = WAY_W'(w);
            end
        end
        evict  = !up_match && !have_free;
        wr_way = up_match ? up_hit_way : (have_free ? free_way : rr_q[up_idx]);
    end

    // A flush in the same cycle drops the update entirely.
    assign do_update = up_valid && !flush;

    logic lu_ok;
    assign lu_ok = lu_valid && !flush && lu_match;

    // Registered prediction; reads pre-update contents, so same-cycle updates are invisible.
    always_ff @(posedge sysclk or negedge nrst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!nrst) begin
            lu_hit    <= 1'b0;
            lu_taken  <= 1'b0;
            lu_target <= '0;
        end else begin
            lu_hit    <= lu_ok;
            lu_taken  <= lu_ok && ctr_q[lu_idx][lu_way][1];
            lu_target <= lu_ok ? target_q[lu_idx][lu_way] : '0;
        end
    end

    // Control state: valid bits, direction counters and round-robin pointers.
    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    ctr_q[s][w]   <= 2'd0;
                end
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                end
            end
        end else if (do_update) begin
            if (up_match) begin
                if (up_taken) begin
                    if (ctr_q[up_idx][wr_way] != 2'd3)
                        ctr_q[up_idx][wr_way] <= ctr_q[up_idx][wr_way] + 2'd1;
                end else begin
                    if (ctr_q[up_idx][wr_way] != 2'd0)
                        ctr_q[up_idx][wr_way] <= ctr_q[up_idx][wr_way] - 2'd1;
                end
            end else if (up_taken) begin
                valid_q[up_idx][wr_way] <= 1'b1;
                ctr_q[up_idx][wr_way]   <= 2'd2;
                if (evict) begin
                    rr_q[up_idx] <= (rr_q[up_idx] == WAY_W'(WAYS - 1)) ? '0
                                  : rr_q[up_idx] + WAY_W'(1);
                end
            end
        end
    end

    // Tag/target payload; written only on allocation or taken hit.
    always_ff @(posedge sysclk) begin
        // NOTE: payload arrays carry no reset; valid_q gates every use of them.
        if (do_update && up_taken) begin
            target_q[up_idx][wr_way] <= up_target;
            if (!up_match)
                tag_q[up_idx][wr_way] <= up_tag;
        end
    end

`ifdef BTB_STATS_EN
    // Usage counters; cleared only by reset, wrap naturally at 2^32.
    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
        end else begin
            stat_lookups <= stat_lookups + 32'(lu_valid);
            stat_hits    <= stat_hits + 32'(lu_hit);
        end
    end
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc (default parameters: 32-bit PC, 64 sets, 2 ways).
// Directed vector table for the documented scenarios, then randomized traffic
// against a slot-level behavioural model keyed by the full word address.
module tb_btb_assoc;

    localparam int ADDR_W = 32;
    localparam int SETS   = 64;
    localparam int WAYS   = 2;

    logic              sysclk = 1'b0;
    logic              nrst;
    logic              lu_valid;
    logic [ADDR_W-1:0] lu_pc;
    logic              lu_hit;
    logic              lu_taken;
    logic [ADDR_W-1:0] lu_target;
    logic              up_valid;
    logic [ADDR_W-1:0] up_pc;
    logic              up_taken;
    logic [ADDR_W-1:0] up_target;
    logic              flush;
`ifdef BTB_STATS_EN
    logic [31:0]       stat_lookups;
    logic [31:0]       stat_hits;
`endif

    btb_assoc #(.ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS)) dut (
        .sysclk    (sysclk),
        .nrst      (nrst),
        .lu_valid  (lu_valid),
        .lu_pc     (lu_pc),
        .lu_hit    (lu_hit),
        .lu_taken  (lu_taken),
        .lu_target (lu_target),
        .up_valid  (up_valid),
        .up_pc     (up_pc),
        .up_taken  (up_taken),
        .up_target (up_target),
        .flush     (flush)
`ifdef BTB_STATS_EN
        ,
        .stat_lookups (stat_lookups),
        .stat_hits    (stat_hits)
`endif
    );

    always #5 sysclk = ~sysclk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic        lv;
        logic [31:0] lpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic        fl;
        logic        eh;
        logic        et;
        logic [31:0] etg;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic lv, input logic [31:0] lpc,
                       input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                       input logic fl, input logic eh, input logic et, input logic [31:0] etg);
        vec_t v;
        v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg;
        v.fl = fl; v.eh = eh; v.et = et; v.etg = etg;
        vecs.push_back(v);
    endtask

    // Drive one cycle at the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic drive(input logic lv, input logic [31:0] lpc,
                         input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                         input logic fl);
        @(negedge sysclk);
        lu_valid = lv; lu_pc = lpc; up_valid = uv; up_pc = upc;
        up_taken = ut; up_target = utg; flush = fl;
        @(posedge sysclk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        nrst = 1'b0;
        lu_valid = 1'b0; lu_pc = '0; up_valid = 1'b0; up_pc = '0;
        up_taken = 1'b0; up_target = '0; flush = 1'b0;
        repeat (2) @(negedge sysclk);
        nrst = 1'b1;
    endtask

    // Behavioural model: each set holds WAYS slots keyed by the full word address.
    logic        m_valid [SETS][WAYS];
    logic [29:0] m_key   [SETS][WAYS];
    logic [31:0] m_tgt   [SETS][WAYS];
    int          m_ctr   [SETS][WAYS];
    int          m_rr    [SETS];

    function automatic void m_clear(input bit all);
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                if (all) m_ctr[s][w] = 0;
            end
        end
    endfunction

    function automatic int m_find(input logic [31:0] pc);
        int s = int'((pc >> 2) % SETS);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_key[s][w] == pc[31:2]) return w;
        return -1;
    endfunction

    function automatic void m_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        int s = int'((pc >> 2) % SETS);
        int w = m_find(pc);
        if (w >= 0) begin
            if (taken) begin
                m_ctr[s][w] = (m_ctr[s][w] < 3) ? m_ctr[s][w] + 1 : 3;
                m_tgt[s][w] = tgt;
            end else begin
                m_ctr[s][w] = (m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0;
            end
        end else if (taken) begin
            int v = -1;
            for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[s][i]) v = i;
            if (v < 0) begin
                v = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % WAYS;
            end
            m_valid[s][v] = 1'b1;
            m_key[s][v]   = pc[31:2];
            m_tgt[s][v]   = tgt;
            m_ctr[s][v]   = 2;
        end
    endfunction

    initial begin
        nrst = 1'b0;
        lu_valid = 1'b0; lu_pc = '0; up_valid = 1'b0; up_pc = '0;
        up_taken = 1'b0; up_target = '0; flush = 1'b0;
        #2;
        check("reset_hit", 32'(lu_hit), 32'd0);
        check("reset_taken", 32'(lu_taken), 32'd0);
        check("reset_target", lu_target, 32'd0);
        do_reset();

        //  lv  lpc        uv  upc        ut  utg         fl  eh  et  etg
        add(1, 32'h100, 0, 32'h0,   0, 32'h0,    0, 0, 0, 32'h0);    // empty miss
        add(0, 32'h0,   1, 32'h100, 1, 32'h200,  0, 0, 0, 32'h0);    // allocate ctr=2
        add(1, 32'h100, 0, 32'h0,   0, 32'h0,    0, 1, 1, 32'h200);
        add(1, 32'h100, 1, 32'h100, 0, 32'h0,    0, 1, 1, 32'h200);  // sees ctr=2
        add(1, 32'h100, 1, 32'h100, 0, 32'h0,    0, 1, 0, 32'h200);  // sees ctr=1
        add(1, 32'h100, 0, 32'h0,   0, 32'h0,    0, 1, 0, 32'h200);  // ctr=0
        add(1, 32'h100, 1, 32'h100, 0, 32'h0,    0, 1, 0, 32'h200);  // floor at 0
        add(1, 32'h100, 1, 32'h100, 1, 32'h240,  0, 1, 0, 32'h200);  // ctr 0->1, new target
        add(1, 32'h100, 0, 32'h0,   0, 32'h0,    0, 1, 0, 32'h240);
        add(0, 32'h0,   1, 32'h200, 1, 32'h1000, 0, 0, 0, 32'h0);    // way1
        add(0, 32'h0,   1, 32'h300, 1, 32'h2000, 0, 0, 0, 32'h0);    // evicts way0 (0x100)
        add(1, 32'h100, 0, 32'h0,   0, 32'h0,    0, 0, 0, 32'h0);
        add(1, 32'h200, 0, 32'h0,   0, 32'h0,    0, 1, 1, 32'h1000);
        add(1, 32'h300, 0, 32'h0,   0, 32'h0,    0, 1, 1, 32'h2000);
        add(0, 32'h0,   1, 32'h400, 1, 32'h3000, 0, 0, 0, 32'h0);    // rr=1 -> evicts 0x200
        add(1, 32'h200, 0, 32'h0,   0, 32'h0,    0, 0, 0, 32'h0);
        add(1, 32'h400, 0, 32'h0,   0, 32'h0,    0, 1, 1, 32'h3000);
        add(1, 32'h300, 0, 32'h0,   0, 32'h0,    0, 1, 1, 32'h2000);
        add(1, 32'h104, 1, 32'h104, 1, 32'h400,  0, 0, 0, 32'h0);    // read-before-write
        add(1, 32'h104, 0, 32'h0,   0, 32'h0,    0, 1, 1, 32'h400);
        add(0, 32'h0,   1, 32'h104, 1, 32'h404,  0, 0, 0, 32'h0);    // ctr 3
        add(0, 32'h0,   1, 32'h104, 1, 32'h408,  0, 0, 0, 32'h0);    // saturates at 3
        add(1, 32'h104, 1, 32'h104, 0, 32'h0,    0, 1, 1, 32'h408);  // 3 -> 2
        add(1, 32'h104, 0, 32'h0,   0, 32'h0,    0, 1, 1, 32'h408);
        add(0, 32'h0,   1, 32'h108, 0, 32'h77,   0, 0, 0, 32'h0);    // miss not-taken: no alloc
        add(1, 32'h108, 0, 32'h0,   0, 32'h0,    0, 0, 0, 32'h0);
        add(0, 32'h0,   1, 32'h10C, 1, 32'h50,   0, 0, 0, 32'h0);
        add(1, 32'h104, 1, 32'h500, 1, 32'h600,  1, 0, 0, 32'h0);    // flush drops update
        add(1, 32'h500, 0, 32'h0,   0, 32'h0,    0, 0, 0, 32'h0);
        add(1, 32'h104, 0, 32'h0,   0, 32'h0,    0, 0, 0, 32'h0);
        add(1, 32'h300, 0, 32'h0,   0, 32'h0,    0, 0, 0, 32'h0);
        add(1, 32'h10C, 0, 32'h0,   0, 32'h0,    0, 0, 0, 32'h0);
        add(0, 32'h0,   1, 32'h300, 1, 32'h700,  0, 0, 0, 32'h0);
        add(1, 32'h300, 0, 32'h0,   0, 32'h0,    0, 1, 1, 32'h700);

        foreach (vecs[i]) begin
            drive(vecs[i].lv, vecs[i].lpc, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utg, vecs[i].fl);
            check($sformatf("vec%0d_hit", i), 32'(lu_hit), 32'(vecs[i].eh));
            check($sformatf("vec%0d_taken", i), 32'(lu_taken), 32'(vecs[i].et));
            check($sformatf("vec%0d_target", i), lu_target, vecs[i].etg);
        end

        // Asynchronous reset clears a live hit without waiting for a clock edge.
        drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("pre_async_hit", 32'(lu_hit), 32'd1);
        @(negedge sysclk);
        #2;
        nrst = 1'b0;
        #1;
        check("async_rst_hit", 32'(lu_hit), 32'd0);
        check("async_rst_target", lu_target, 32'd0);
        @(negedge sysclk);
        nrst = 1'b1;
        drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("post_rst_miss", 32'(lu_hit), 32'd0);

        // Randomized traffic over two sets and four tags so hits, evictions and flushes occur.
        do_reset();
        m_clear(1'b1);
        for (int c = 0; c < 3000; c++) begin
            logic        lv, uv, ut, fl, eh, et;
            logic [31:0] lpc, upc, utg, etg;
            int          s, w;
            lv  = 1'($urandom_range(0, 3) != 0);
            lpc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
            uv  = 1'($urandom_range(0, 1));
            upc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
            ut  = 1'($urandom_range(0, 2) != 0);
            utg = $urandom;
            fl  = 1'($urandom_range(0, 49) == 0);
            s   = int'((lpc >> 2) % SETS);
            w   = m_find(lpc);
            eh  = lv && !fl && (w >= 0);
            et  = eh && (m_ctr[s][w] >= 2);
            etg = eh ? m_tgt[s][w] : 32'h0;
            if (fl) m_clear(1'b0);
            else if (uv) m_update(upc, ut, utg);
            drive(lv, lpc, uv, upc, ut, utg, fl);
            check($sformatf("rnd%0d_hit", c), 32'(lu_hit), 32'(eh));
            check($sformatf("rnd%0d_taken", c), 32'(lu_taken), 32'(et));
            check($sformatf("rnd%0d_target", c), lu_target, etg);
        end

`ifdef BTB_STATS_EN
        do_reset();
        #1;
        check("stat_rst_lookups", stat_lookups, 32'd0);
        drive(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
        for (int i = 0; i < 10; i++)
            drive(1'b1, (i < 4) ? 32'h100 : 32'h800, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        idle();
        idle();
        check("stat_lookups", stat_lookups, 32'd10);
        check("stat_hits", stat_hits, 32'd4);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        idle();
        check("stat_flush_lookups", stat_lookups, 32'd10);
        check("stat_flush_hits", stat_hits, 32'd4);
        do_reset();
        #1;
        check("stat_nrst_lookups", stat_lookups, 32'd0);
        check("stat_nrst_hits", stat_hits, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
